lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU. Takes the ALU sum (base + offset) as the effective address for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Issues a single-beat request/ack transaction on the data-memory port and aligns store data into byte lanes.
- Extracts and extends load data, and returns a result to writeback.
- Holds the pipeline via o_busy while a transaction is in flight.

Parameters:
- ACK_TIMEOUT, 255, max cycles in REQ waiting for i_mem_ack before abort; 0 disables the timeout.

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  EX stage presents an instruction this cycle
- i_mnemonic  in  6  instruction code, encodings from include/define.svh
- i_addr  in  32  effective address (ALU result)
- i_store_data  in  32  rs2 value for stores
- o_busy  out  1  stall request to the pipeline
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  1 = store, 0 = load
- o_mem_addr  out  32  word address, {addr[31:2],2'b00}
- o_mem_wstrb  out  4  byte-lane write strobes (0000 for loads)
- o_mem_wdata  out  32  lane-aligned store data
- i_mem_ack  in  1  request completed; rdata valid this cycle for loads
- i_mem_rdata  in  32  load word
- o_done  out  1  one-cycle pulse when the operation retires
- o_wb_valid  out  1  one-cycle pulse, load result valid
- o_wb_data  out  32  extended load result
- o_bus_err  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs 0. Reset mid-transaction drops o_mem_req immediately and discards the operation.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If i_valid and the mnemonic is a load/store, register addr, mnemonic, strobe and wdata, then go to REQ.
  - o_busy=1 combinationally in that accept cycle.
  - Other mnemonics, or i_valid=0: stay in IDLE with o_busy=0.
- REQ:
  - o_mem_req=1; o_busy=1; request fields stable.
  - Counter increments each cycle.
  - On i_mem_ack: capture formatted rdata (loads only), go to DONE.
  - If ACK_TIMEOUT!=0 and counter reaches ACK_TIMEOUT without ack: go to DONE with o_bus_err=1 and o_wb_valid=0.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - Exactly one cycle: o_done=1; o_wb_valid=1 for loads; o_busy=0.
  - Return to IDLE; no new accept in this cycle.
  - o_wb_data holds its value until the next load completes.
- Minimum latency: accept at cycle N, request at N+1, ack at N+1, o_done at N+2.
- i_mem_ack outside REQ is ignored.
- Store lanes:
  - SB: wstrb = 0001<<addr[1:0]; wdata = byte replicated x4.
  - SH: wstrb = 0011<<(2*addr[1]); wdata = halfword replicated x2.
  - SW: wstrb = 1111; wdata as-is.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned halfword/word accesses (no macro): low offset bits beyond the access size are ignored. LH at offset 1 behaves as offset 0; LW/SW at any offset behave as offset 0.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a LH/LHU/SH with addr[0]=1, or a LW/SW with addr[1:0]!=0, issues no memory request.
  - FSM goes IDLE->DONE directly.
  - DONE cycle: extra output o_misalign (1 bit, reset 0) = 1, o_done=1, o_wb_valid=0.
- Undefined: port o_misalign absent; truncation rule above applies.

Test Plan:
- SW addr=0x104, data=0xDEADBEEF, ack on the first REQ cycle -> o_mem_addr=0x104, wstrb=1111, wdata=0xDEADBEEF; o_done two cycles after accept; o_wb_valid=0.
- SB addr=0x203, data=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5.
- LB addr=0x102, rdata=0x12F03456, ack delayed 3 cycles -> o_busy high for accept + 3 REQ cycles; o_wb_data=0xFFFFFFF0. LBU at the same address -> 0x000000F0.
- LH addr=0x106, rdata=0x80017FFF -> 0xFFFF8001; LHU -> 0x00008001.
- ACK_TIMEOUT=4, never ack -> o_mem_req high for 4 cycles, then o_bus_err=1 and o_done=1 for one cycle; return to IDLE.
- Assert i_rst during REQ -> o_mem_req=0 immediately; later ack ignored; next LW completes normally. With LSU_MISALIGN_TRAP_EN: LW addr=0x102 -> no o_mem_req, o_misalign=1 one cycle after accept.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sitting behind the ALU.
// Takes the effective address from the ALU and issues one request/ack
// transaction per load or store. Store data is placed into the correct byte
// lanes, and load data is selected and sign- or zero-extended for writeback.
// While a transaction is in flight the unit holds the pipeline with o_busy.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword
// and word accesses. A trapped access issues no memory request and pulses
// o_misalign. With the macro undefined the port is absent, and the address
// offset bits below the access size are ignored.
//
// Parameters:
//   ACK_TIMEOUT  : cycles spent in REQ without an ack before the access is
//                  aborted; 0 disables the timeout
// Ports:
//   i_clk, i_rst              : clock; asynchronous active-high reset
//   i_valid, i_mnemonic       : EX-stage instruction strobe and opcode
//   i_addr, i_store_data      : effective address and rs2 store value
//   o_busy                    : pipeline stall (combinational in the accept cycle)
//   o_mem_req/we/addr/wstrb/wdata, i_mem_ack, i_mem_rdata : data-memory port
//   o_done, o_wb_valid, o_wb_data : retire pulse and load writeback
//   o_bus_err                 : timeout abort pulse
//   o_misalign                : misaligned-access pulse (LSU_MISALIGN_TRAP_EN only)
module lsu_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [5:0]  i_mnemonic,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        o_misalign,
`endif
  output logic        o_bus_err
);

  // Load/store opcode encodings shared with the decoder.
  localparam logic [5:0] MN_LB  = 6'd1;
  localparam logic [5:0] MN_LH  = 6'd2;
  localparam logic [5:0] MN_LW  = 6'd3;
  localparam logic [5:0] MN_LBU = 6'd4;
  localparam logic [5:0] MN_LHU = 6'd5;
  localparam logic [5:0] MN_SB  = 6'd6;
  localparam logic [5:0] MN_SH  = 6'd7;
  localparam logic [5:0] MN_SW  = 6'd8;

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         mn_q, mn_d;
  logic [1:0]         off_q, off_d;
  logic               req_q, req_d, we_q, we_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, wb_data_q, wb_data_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               done_q, done_d, wbv_q, wbv_d, err_q, err_d, mis_q, mis_d;

  logic               is_load_c, is_store_c, accept_c, misalign_c, timeout_c, q_load_c;
  logic [3:0]         lane_strb_c;
  logic [31:0]        lane_data_c, load_fmt_c;
  logic [7:0]         rbyte_c;
  logic [15:0]        rhalf_c;

  // Classify the incoming opcode and the registered one.
  always_comb begin
    is_load_c  = (i_mnemonic == MN_LB) || (i_mnemonic == MN_LH) || (i_mnemonic == MN_LW) ||
                 (i_mnemonic == MN_LBU) || (i_mnemonic == MN_LHU);
    is_store_c = (i_mnemonic == MN_SB) || (i_mnemonic == MN_SH) || (i_mnemonic == MN_SW);
    q_load_c   = (mn_q == MN_LB) || (mn_q == MN_LH) || (mn_q == MN_LW) ||
                 (mn_q == MN_LBU) || (mn_q == MN_LHU);
    accept_c   = (state_q == IDLE) && i_valid && (is_load_c || is_store_c);
    timeout_c  = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_c = ((i_mnemonic == MN_LH || i_mnemonic == MN_LHU || i_mnemonic == MN_SH) && i_addr[0]) ||
                 ((i_mnemonic == MN_LW || i_mnemonic == MN_SW) && (i_addr[1:0] != 2'b00));
`else
    misalign_c = 1'b0;
`endif
  end

  // Store lane steering; offset bits below the access size are dropped.
  always_comb begin
    lane_strb_c = 4'b0000;
    lane_data_c = 32'h0;
    case (i_mnemonic)
      MN_SB: begin
        lane_strb_c = 4'b0001 << i_addr[1:0];
        lane_data_c = {4{i_store_data[7:0]}};
      end
      MN_SH: begin
        lane_strb_c = 4'b0011 << {i_addr[1], 1'b0};
        lane_data_c = {2{i_store_data[15:0]}};
      end
      MN_SW: begin
        lane_strb_c = 4'b1111;
        lane_data_c = i_store_data;
      end
      default: ;
    endcase
  end

  // Load byte/halfword select and extension.
  always_comb begin
    rbyte_c = 8'(i_mem_rdata >> {off_q, 3'b000});
    rhalf_c = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (mn_q)
      MN_LB:   load_fmt_c = {{24{rbyte_c[7]}}, rbyte_c};
      MN_LBU:  load_fmt_c = {24'h0, rbyte_c};
      MN_LH:   load_fmt_c = {{16{rhalf_c[15]}}, rhalf_c};
      MN_LHU:  load_fmt_c = {16'h0, rhalf_c};
      default: load_fmt_c = i_mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mn_d      = mn_q;
    off_d     = off_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    wb_data_d = wb_data_q;
    done_d    = 1'b0;
    wbv_d     = 1'b0;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          mn_d    = i_mnemonic;
          off_d   = i_addr[1:0];
          cnt_d   = '0;
          we_d    = is_store_c;
          addr_d  = {i_addr[31:2], 2'b00};
          wstrb_d = lane_strb_c;
          wdata_d = lane_data_c;
          if (misalign_c) begin
            // Trapped access retires without touching memory.
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ack takes priority over a coincident timeout.
        if (i_mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          if (q_load_c) begin
            wbv_d     = 1'b1;
            wb_data_d = load_fmt_c;
          end
        end else if (timeout_c) begin
          state_d = DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mn_q      <= 6'h0;
      off_q     <= 2'b00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wstrb_q   <= 4'h0;
      wdata_q   <= 32'h0;
      wb_data_q <= 32'h0;
      done_q    <= 1'b0;
      wbv_q     <= 1'b0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mn_q      <= mn_d;
      off_q     <= off_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      wb_data_q <= wb_data_d;
      done_q    <= done_d;
      wbv_q     <= wbv_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
    end
  end

  // Stall covers the accept cycle and every REQ cycle.
  assign o_busy      = accept_c || (state_q == REQ);
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_mem_wdata = wdata_q;
  assign o_done      = done_q;
  assign o_wb_valid  = wbv_q;
  assign o_wb_data   = wb_data_q;
  assign o_bus_err   = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign o_misalign  = mis_q;
`else
  logic unused_mis;
  assign unused_mis  = mis_q;
`endif

endmodule
